dense_param_loader: RTL and testbench
=====================================

Name: dense_param_loader

Overview:
- Writer side of the dense-layer parameter memories: accepts a serial stream of fixed-point words and writes biases, then weights, into the bias/weight arrays that a dense layer reads.
- Weight placement matches the dense-layer read order: address = in_idx*NB_NEURONS + neuron_idx (stride = NB_NEURONS).
- Sits between the host/DMA word stream and the per-layer parameter RAMs.
- One instance per dense layer: 42->24, 24->1, 96->22.

Parameters:
- FIXED, 32, word width of every bias/weight.
- NB_INPUT, 42, input count of the target dense layer.
- NB_NEURONS, 24, neuron count of the target dense layer.
- ADDR_W, 11, write address width; must satisfy 2^ADDR_W >= NB_INPUT*NB_NEURONS.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a load.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word.
- s_data  in  FIXED  stream word.
- s_last  in  1  marks the final word of the load.
- wr_en  out  1  memory write strobe.
- wr_sel  out  1  0 = bias array, 1 = weight array.
- wr_addr  out  ADDR_W  write index.
- wr_data  out  FIXED  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky framing error.

Behaviour:
- Reset (rst low, asynchronous): state IDLE. Counters cleared. s_ready, wr_en, wr_sel, busy, done, err = 0. wr_addr and wr_data = 0.
- Beat acceptance: a beat is accepted when s_valid and s_ready are both high on a rising edge.
- s_ready: high only in BIAS and WEIGHT; combinational from state. Words presented in other states are never accepted.
- IDLE:
  - start -> BIAS; clear counters and err; busy = 1.
  - Other inputs ignored.
- BIAS:
  - Accepted beat k (0..NB_NEURONS-1) -> next cycle wr_en = 1, wr_sel = 0, wr_addr = k, wr_data = s_data.
  - After beat NB_NEURONS-1 -> WEIGHT.
  - s_last on any bias beat -> ERR; that beat is not written.
- WEIGHT:
  - Counters n (neuron, inner) and i (input, outer). Beat order: n increments fastest, wraps to 0 at NB_NEURONS and increments i.
  - Accepted beat -> next cycle wr_en = 1, wr_sel = 1, wr_addr = i*NB_NEURONS + n.
  - Address is held in a running register incremented by 1 per beat. It is not computed with a multiplier.
  - Final beat (i = NB_INPUT-1, n = NB_NEURONS-1) with s_last = 1 -> write it, then DONE.
  - Final beat with s_last = 0 -> ERR; the beat is still written.
  - s_last on any earlier weight beat -> ERR; that beat is not written.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
- ERR:
  - err = 1 and busy = 0; no further writes.
  - Held until the next start (-> BIAS, err cleared) or reset.
- Write latency: exactly one cycle from beat acceptance to wr_en.
  - wr_en is high for one cycle per accepted beat.
  - Back-to-back beats give back-to-back writes; there is no throughput bubble.
- start while busy is ignored; the current load continues unaffected.
- start in the same cycle as a DONE exit is ignored; the next start from IDLE is honoured.
- Reset mid-load: immediate return to IDLE. The partially written memory is left as is; no done pulse.
- Data words are passed bit-exact; no arithmetic on s_data.
- Total accepted beats per successful load = NB_NEURONS + NB_INPUT*NB_NEURONS.

Decomposition:
- Shared package dense_pkg:
  - State encoding constants (IDLE, BIAS, WEIGHT, DONE, ERR).
  - WR_SEL_BIAS / WR_SEL_WEIGHT constants.
  - Per-layer size constants: 42/24, 24/1, 96/22.
- One natural sub-module, dense_idx_counter: nested inner/outer wrap counter plus linear address register.
- FSM and write register stay in the top module.

Test Plan:
- NB_INPUT=3, NB_NEURONS=2, 8 beats with data 0x100..0x107, s_valid always high, s_last on beat 7 -> expected:
  - Bias writes addr 0,1 = 0x100,0x101.
  - Weight writes addr 0..5 = 0x102..0x107, each one cycle after acceptance.
  - done pulse one cycle after the last write; busy low afterwards.
- Same load with s_valid toggled every other cycle -> identical write sequence with gaps; 8 writes total; done once.
- s_last asserted on beat 4 (weight addr 2) -> no write for beat 4; err = 1, busy = 0. Later beats: s_ready = 0, no writes. Next start clears err.
- s_last missing on beat 7 -> beat 7 written to weight addr 5; err = 1; no done.
- Reset asserted asynchronously after beat 3 -> all outputs 0 immediately (not waiting for a clock edge); state IDLE. start after reset release reloads from bias addr 0.
- start pulsed again during BIAS on beat 1 -> ignored; addresses continue 1, then weight 0..5; a single done.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared encodings and layer sizes for the dense-layer parameter loader.
package dense_pkg;

  // Loader FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BIAS   = 3'd1,
    ST_WEIGHT = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Target array select on the write port.
  localparam logic WR_SEL_BIAS   = 1'b0;
  localparam logic WR_SEL_WEIGHT = 1'b1;

  // Dense layer geometries in the network (inputs / neurons).
  localparam int L0_NB_INPUT   = 42;
  localparam int L0_NB_NEURONS = 24;
  localparam int L1_NB_INPUT   = 24;
  localparam int L1_NB_NEURONS = 1;
  localparam int L2_NB_INPUT   = 96;
  localparam int L2_NB_NEURONS = 22;

endpackage

// File: rtl/dense_idx_counter.sv
// Nested inner/outer wrap counter with a running linear address.
// The inner index moves fastest, so the linear address equals
// outer*NB_INNER + inner without needing a multiplier.
module dense_idx_counter #(
  parameter int NB_INNER = 24,
  parameter int NB_OUTER = 42,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_inner_last,
  output logic              o_outer_last
);

  localparam int IW = (NB_INNER > 1) ? $clog2(NB_INNER) : 1;
  localparam int OW = (NB_OUTER > 1) ? $clog2(NB_OUTER) : 1;
  localparam logic [IW-1:0] INNER_MAX = IW'(NB_INNER - 1);
  localparam logic [OW-1:0] OUTER_MAX = OW'(NB_OUTER - 1);

  logic [IW-1:0]     r_inner;
  logic [OW-1:0]     r_outer;
  logic [ADDR_W-1:0] r_addr;

  // Clear has priority; otherwise step inner, carrying into outer on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inner <= '0;
      r_outer <= '0;
      r_addr  <= '0;
    end else if (i_clr) begin
      r_inner <= '0;
      r_outer <= '0;
      r_addr  <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
      if (r_inner == INNER_MAX) begin
        r_inner <= '0;
        r_outer <= (r_outer == OUTER_MAX) ? '0 : r_outer + 1'b1;
      end else begin
        r_inner <= r_inner + 1'b1;
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_inner_last = (r_inner == INNER_MAX);
  assign o_outer_last = (r_outer == OUTER_MAX);

endmodule

// File: rtl/dense_param_loader.sv
// Writes a serial word stream into a dense layer's bias array, then its
// weight array in the layer's read order (in_idx*NB_NEURONS + neuron_idx).
//
// Stream handshake: a word transfers on a rising edge where s_valid and
// s_ready are both high. s_ready depends only on state (BIAS or WEIGHT);
// s_valid may toggle freely and the producer holds s_data/s_last until
// the transfer. Each transferred word produces at most one write, one
// cycle later.
module dense_param_loader
  import dense_pkg::*;
#(
  parameter int FIXED      = 32,
  parameter int NB_INPUT   = 42,
  parameter int NB_NEURONS = 24,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FIXED-1:0]  s_data,
  input  logic              s_last,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [FIXED-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  state_t            r_state;
  logic              r_wr_en;
  logic              r_wr_sel;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [FIXED-1:0]  r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_beat;
  logic              w_final;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic [ADDR_W-1:0] w_addr;
  logic              w_inner_last;
  logic              w_outer_last;

  dense_idx_counter #(
    .NB_INNER (NB_NEURONS),
    .NB_OUTER (NB_INPUT),
    .ADDR_W   (ADDR_W)
  ) u_idx (
    .clk          (clk),
    .rst_n        (rst),
    .i_clr        (w_cnt_clr),
    .i_inc        (w_cnt_inc),
    .o_addr       (w_addr),
    .o_inner_last (w_inner_last),
    .o_outer_last (w_outer_last)
  );

  // Handshake and counter control; the counter restarts at each load and
  // again at the bias-to-weight boundary so weights begin at address 0.
  always_comb begin
    s_ready   = (r_state == ST_BIAS) || (r_state == ST_WEIGHT);
    w_beat    = s_valid && s_ready;
    w_final   = w_inner_last && w_outer_last;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR: w_cnt_clr = start;
      ST_BIAS: begin
        if (w_beat && !s_last) begin
          w_cnt_clr = w_inner_last;
          w_cnt_inc = !w_inner_last;
        end
      end
      ST_WEIGHT: w_cnt_inc = w_beat && (!s_last || w_final);
      default: ;
    endcase
  end

  // Loader FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= WR_SEL_BIAS;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            r_state <= ST_BIAS;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_BIAS: begin
          if (w_beat) begin
            if (s_last) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_sel  <= WR_SEL_BIAS;
              r_wr_addr <= w_addr;
              r_wr_data <= s_data;
              if (w_inner_last) r_state <= ST_WEIGHT;
            end
          end
        end
        ST_WEIGHT: begin
          if (w_beat) begin
            if (s_last && !w_final) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_sel  <= WR_SEL_WEIGHT;
              r_wr_addr <= w_addr;
              r_wr_data <= s_data;
              if (w_final) begin
                if (s_last) begin
                  r_state <= ST_DONE;
                end else begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dense_param_loader.sv
// Bench for dense_param_loader with a 3-input, 2-neuron layer.
module tb_dense_param_loader;

  localparam int FIXED  = 32;
  localparam int NB_IN  = 3;
  localparam int NB_N   = 2;
  localparam int ADDR_W = 4;
  localparam int NBEATS = NB_N + NB_IN * NB_N;
  localparam int EW     = 16 + 1 + ADDR_W + FIXED;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [FIXED-1:0]  s_data = '0;
  logic              s_last = 1'b0;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [FIXED-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];

  dense_param_loader #(
    .FIXED      (FIXED),
    .NB_INPUT   (NB_IN),
    .NB_NEURONS (NB_N),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock, cycle counter and run-time guard.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int c, input logic sel, input int addr, input logic [FIXED-1:0] d);
    return {16'(c), sel, ADDR_W'(addr), d};
  endfunction

  // Scoreboard: every write is popped and compared, including its cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'(cyc), wr_sel, wr_addr, wr_data}, '0);
      end else begin
        check("write", {16'(cyc), wr_sel, wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present beat k; optionally idle one cycle first or raise start alongside.
  task automatic do_beat(input int k, input logic last, input bit gap,
                         input bit expect_wr, input bit with_start);
    bit ok;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = 32'h100 + 32'(k);
    s_last  = last;
    start   = with_start;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      else @(posedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 64'(s_ready), 64'(1));
    end else begin
      @(posedge clk); #1;
      if (expect_wr) begin
        if (k < NB_N) exp_q.push_back(mk(cyc, 1'b0, k, 32'h100 + 32'(k)));
        else          exp_q.push_back(mk(cyc, 1'b1, k - NB_N, 32'h100 + 32'(k)));
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
  endtask

  // Complete good load followed by the done-pulse checks.
  task automatic good_load(input string tag, input bit gaps, input int start_beat);
    int d0;
    pulse_start();
    @(negedge clk);
    check({tag, "_busy_start"}, 64'(busy), 64'(1));
    @(posedge clk); #1;
    d0 = done_cnt;
    for (int k = 0; k < NBEATS; k++)
      do_beat(k, k == NBEATS - 1, gaps, 1'b1, k == start_beat);
    @(negedge clk);
    check({tag, "_done_early"}, 64'(done), 64'(0));
    check({tag, "_busy_last"}, 64'(busy), 64'(1));
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'(1));
    check({tag, "_state_idle"}, 64'(dbg_state), 64'(0));
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(s_ready), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_addr", 64'(wr_addr), 64'(0));
    check("rst_data", 64'(wr_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    // Ignored input while idle: no acceptance.
    s_valid = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    @(posedge clk); #1;

    // Back-to-back load, then the same load with gaps.
    good_load("b2b", 1'b0, -1);
    good_load("gap", 1'b1, -1);

    // Early s_last on beat 4: not written, error held, stream refused.
    pulse_start();
    for (int k = 0; k < 4; k++) do_beat(k, 1'b0, 1'b0, 1'b1, 1'b0);
    do_beat(4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("early_err", 64'(err), 64'(1));
    check("early_busy", 64'(busy), 64'(0));
    s_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("early_ready", 64'(s_ready), 64'(0));
    end
    s_valid = 1'b0;
    check("early_q_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("restart_err_clr", 64'(err), 64'(0));
    check("restart_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;

    // Missing s_last on the final beat: written, error, no done.
    d0 = done_cnt;
    for (int k = 0; k < NBEATS; k++) do_beat(k, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("nolast_err", 64'(err), 64'(1));
    check("nolast_busy", 64'(busy), 64'(0));
    check("nolast_no_done", 64'(done_cnt - d0), 64'(0));
    check("nolast_q_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;

    // Asynchronous reset right after beat 3 is accepted.
    pulse_start();
    for (int k = 0; k < 3; k++) do_beat(k, 1'b0, 1'b0, 1'b1, 1'b0);
    do_beat(3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_wr_en", 64'(wr_en), 64'(1));
    rst = 1'b0;
    #1;
    check("arst_wr_en", 64'(wr_en), 64'(0));
    check("arst_wr_sel", 64'(wr_sel), 64'(0));
    check("arst_addr", 64'(wr_addr), 64'(0));
    check("arst_data", 64'(wr_data), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_ready", 64'(s_ready), 64'(0));
    check("arst_state", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    good_load("after_rst", 1'b0, -1);

    // start raised again during bias beat 1 is ignored.
    good_load("restart_busy", 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
